// File: rtl/twowire_pkg.sv
// ============================================================================
// twowire_pkg
// Shared definitions for the Two-Wire Debug DTM: command codes, FSM states,
// default connect sequence.
// Revision: 1.0
// ============================================================================
`default_nettype none

package twowire_pkg;

    localparam int CMD_WIDTH = 4;

    localparam logic [CMD_WIDTH-1:0] CMD_W_CSR  = 4'd3;
    localparam logic [CMD_WIDTH-1:0] CMD_W_ADDR = 4'd5;
    localparam logic [CMD_WIDTH-1:0] CMD_W_DATA = 4'd9;

    localparam logic [31:0] DEFAULT_CONNECT_SEQ = 32'ha7a3f5d1;

    typedef enum logic [3:0] {
        S_HUNT  = 4'd0,
        S_ADDR  = 4'd1,
        S_IDLE  = 4'd2,
        S_CMD   = 4'd3,
        S_CPAR  = 4'd4,
        S_DISP  = 4'd5,
        S_WDATA = 4'd6,
        S_WPAR  = 4'd7,
        S_TURN1 = 4'd8,
        S_RDATA = 4'd9,
        S_RPAR  = 4'd10,
        S_TURN2 = 4'd11
    } state_e;

    function automatic logic cmd_is_write(input logic [CMD_WIDTH-1:0] c);
        return (c == CMD_W_CSR) || (c == CMD_W_ADDR) || (c == CMD_W_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/twowire_dtm_serial_if.sv
// ============================================================================
// twowire_dtm_serial_if
// Handshake between the serial front-end (master) and the DTM core (slave).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface twowire_dtm_serial_if #(
    parameter int W_CMD = 4
);
    logic             connected;
    logic             disconnect_now;
    logic [3:0]       mdropaddr;
    logic [W_CMD-1:0] cmd;
    logic             cmd_vld;
    logic             cmd_payload_end;
    logic             serial_parity_err;
    logic             serial_wdata;
    logic             serial_wdata_vld;
    logic             serial_rdata;
    logic             serial_rdata_rdy;

    modport master (
        output connected, cmd, cmd_vld, serial_parity_err,
               serial_wdata, serial_wdata_vld, serial_rdata_rdy,
        input  disconnect_now, mdropaddr, cmd_payload_end, serial_rdata
    );

    modport slave (
        input  connected, cmd, cmd_vld, serial_parity_err,
               serial_wdata, serial_wdata_vld, serial_rdata_rdy,
        output disconnect_now, mdropaddr, cmd_payload_end, serial_rdata
    );
endinterface

`default_nettype wire

// File: rtl/twowire_dtm_serial.sv
// ============================================================================
// twowire_dtm_serial
// Serial front-end of the Two-Wire Debug DTM: connect hunt, command receive,
// payload shifting with turnarounds and even parity.
// Revision: 1.0
// ============================================================================
`default_nettype none

module twowire_dtm_serial
    import twowire_pkg::*;
#(
    parameter int                W_CMD       = CMD_WIDTH,
    parameter int                W_CONN      = 32,
    parameter logic [W_CONN-1:0] CONNECT_SEQ = W_CONN'(DEFAULT_CONNECT_SEQ)
) (
    input  logic dck,
    input  logic drst_n,
    input  logic dio_i,
    output logic dio_o,
    output logic dio_oe,
    twowire_dtm_serial_if.master core
);

    localparam int W_CNT = $clog2((W_CMD > 4) ? W_CMD : 4);

    state_e            r_state;
    logic [W_CONN-1:0] r_hunt;
    logic [3:0]        r_addr;
    logic [W_CMD-1:0]  r_cmd_sh;
    logic [W_CMD-1:0]  r_cmd;
    logic [W_CNT-1:0]  r_cnt;
    logic              r_par;
    logic              r_connected;
    logic              r_cmd_vld;
    logic              r_dio_oe;

    logic [W_CONN-1:0] w_hunt_next;
    logic [3:0]        w_addr_next;
    logic [W_CMD-1:0]  w_cmd_next;
    logic              w_live;

    assign w_hunt_next = {r_hunt[W_CONN-2:0], dio_i};
    assign w_addr_next = {r_addr[2:0], dio_i};
    assign w_cmd_next  = {r_cmd_sh[W_CMD-2:0], dio_i};
    assign w_live      = (r_state != S_HUNT) && (r_state != S_ADDR);

    always_ff @(posedge dck or negedge drst_n) begin
        if (!drst_n) begin
            r_state     <= S_HUNT;
            r_hunt      <= '0;
            r_addr      <= '0;
            r_cmd_sh    <= '0;
            r_cmd       <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_connected <= 1'b0;
            r_cmd_vld   <= 1'b0;
            r_dio_oe    <= 1'b0;
        end else begin
            r_cmd_vld <= 1'b0;
            if (w_live && core.disconnect_now) begin
                r_state     <= S_HUNT;
                r_connected <= 1'b0;
                r_hunt      <= '0;
                r_dio_oe    <= 1'b0;
            end else begin
                case (r_state)
                    S_HUNT: begin
                        r_hunt <= w_hunt_next;
                        if (w_hunt_next == CONNECT_SEQ) begin
                            r_state <= S_ADDR;
                            r_cnt   <= '0;
                        end
                    end
                    S_ADDR: begin
                        r_addr <= w_addr_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (r_cnt == W_CNT'(3)) begin
                            if (w_addr_next == core.mdropaddr) begin
                                r_state     <= S_IDLE;
                                r_connected <= 1'b1;
                            end else begin
                                r_state <= S_HUNT;
                                r_hunt  <= '0;
                            end
                        end
                    end
                    S_IDLE: begin
                        if (!dio_i) begin
                            r_state <= S_CMD;
                            r_cnt   <= '0;
                        end
                    end
                    S_CMD: begin
                        r_cmd_sh <= w_cmd_next;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == W_CNT'(W_CMD - 1)) r_state <= S_CPAR;
                    end
                    S_CPAR: begin
                        if (dio_i == ^r_cmd_sh) begin
                            r_cmd     <= r_cmd_sh;
                            r_cmd_vld <= 1'b1;
                            r_state   <= S_DISP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_DISP: begin
                        r_par   <= 1'b0;
                        r_state <= cmd_is_write(CMD_WIDTH'(r_cmd)) ? S_WDATA : S_TURN1;
                    end
                    S_WDATA: begin
                        r_par <= r_par ^ dio_i;
                        if (core.cmd_payload_end) r_state <= S_WPAR;
                    end
                    S_WPAR:  r_state <= S_IDLE;
                    S_TURN1: begin
                        r_dio_oe <= 1'b1;
                        r_state  <= S_RDATA;
                    end
                    S_RDATA: begin
                        r_par <= r_par ^ core.serial_rdata;
                        if (core.cmd_payload_end) r_state <= S_RPAR;
                    end
                    // Release the line one cycle ahead of S_IDLE so the host can drive again.
                    S_RPAR: begin
                        r_dio_oe <= 1'b0;
                        r_state  <= S_TURN2;
                    end
                    S_TURN2: r_state <= S_IDLE;
                    default: r_state <= S_HUNT;
                endcase
            end
        end
    end

    always_comb begin
        dio_o = 1'b0;
        if (r_state == S_RDATA)     dio_o = core.serial_rdata;
        else if (r_state == S_RPAR) dio_o = r_par;
    end

    assign dio_oe                 = r_dio_oe;
    assign core.connected         = r_connected;
    assign core.cmd               = r_cmd;
    assign core.cmd_vld           = r_cmd_vld;
    assign core.serial_wdata      = dio_i;
    assign core.serial_wdata_vld  = (r_state == S_WDATA);
    assign core.serial_rdata_rdy  = (r_state == S_RDATA);
    assign core.serial_parity_err = ((r_state == S_CPAR) && (dio_i != ^r_cmd_sh)) ||
                                    ((r_state == S_WPAR) && (dio_i != r_par));

endmodule

`default_nettype wire

// File: tb/tb_twowire_dtm_serial.sv
// Bench for twowire_dtm_serial with a stub core; expected events are queued by
// the stimulus and consumed by a negedge monitor.
`default_nettype none

module tb_twowire_dtm_serial;

    localparam logic [31:0] CONN_SEQ = 32'ha7a3f5d1;
    localparam logic [31:0] IDCODE   = 32'h1DEAD0B3;

    localparam int EV_CMD  = 0;
    localparam int EV_PERR = 1;
    localparam int EV_WBIT = 2;
    localparam int EV_DIO  = 3;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic dck = 1'b0;
    logic drst_n;
    logic dio_i;
    logic dio_o;
    logic dio_oe;
    logic [3:0] mdrop;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int start_cyc = -100;
    int cmd_cyc = -100;
    logic prev_oe = 1'b0;
    ev_t exp_q[$];

    // stub core state
    logic [31:0] rsh = '0;
    int          pcnt = 0;

    twowire_dtm_serial_if #(.W_CMD(4)) cif ();

    twowire_dtm_serial #(.W_CMD(4)) dut (
        .dck    (dck),
        .drst_n (drst_n),
        .dio_i  (dio_i),
        .dio_o  (dio_o),
        .dio_oe (dio_oe),
        .core   (cif.master)
    );

    always #5 dck = ~dck;
    always @(posedge dck) cyc <= cyc + 1;

    assign cif.mdropaddr       = mdrop;
    assign cif.serial_rdata    = rsh[0];
    assign cif.disconnect_now  = cif.cmd_vld && (cif.cmd == 4'h0);
    assign cif.cmd_payload_end = (pcnt == 31) && (cif.serial_wdata_vld || cif.serial_rdata_rdy);

    always @(posedge dck) begin
        if (cif.cmd_vld) begin
            pcnt <= 0;
            rsh  <= IDCODE;
        end else if (cif.serial_rdata_rdy) begin
            pcnt <= pcnt + 1;
            rsh  <= {1'b0, rsh[31:1]};
        end else if (cif.serial_wdata_vld) begin
            pcnt <= pcnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic push_ev(input int k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic see_ev(input int k, input logic [31:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d value %0h expected none (cycle %0d)", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.val === v) passes++;
            else $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h (cycle %0d)",
                          k, v, e.kind, e.val, cyc);
        end
    endtask

    always @(negedge dck) begin
        if (drst_n) begin
            if (cif.cmd_vld) begin
                see_ev(EV_CMD, {28'd0, cif.cmd});
                check("start_to_cmd_vld_latency", cyc - start_cyc, 6);
                cmd_cyc = cyc;
            end
            if (cif.serial_parity_err) see_ev(EV_PERR, 32'd0);
            if (cif.serial_wdata_vld)  see_ev(EV_WBIT, {31'd0, cif.serial_wdata});
            if (dio_oe) begin
                see_ev(EV_DIO, {31'd0, dio_o});
                if (!prev_oe) check("cmd_vld_to_read_latency", cyc - cmd_cyc, 2);
            end
            prev_oe = dio_oe;
        end else begin
            prev_oe = 1'b0;
        end
    end

    task automatic bit_(input logic b);
        dio_i = b;
        @(posedge dck);
        #1;
    endtask

    task automatic bits_msb(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_(v[i]);
    endtask

    task automatic connect_seq(input logic [3:0] a);
        bits_msb(CONN_SEQ, 32);
        bits_msb({28'd0, a}, 4);
    endtask

    task automatic send_cmd(input logic [3:0] c, input logic p);
        start_cyc = cyc;
        bit_(1'b0);
        bits_msb({28'd0, c}, 4);
        bit_(p);
    endtask

    task automatic do_read();
        push_ev(EV_CMD, 32'd1);
        for (int i = 0; i < 32; i++) push_ev(EV_DIO, {31'd0, IDCODE[i]});
        push_ev(EV_DIO, {31'd0, ^IDCODE});
        send_cmd(4'h1, 1'b1);
        repeat (40) bit_(1'b1);
        check("dio_oe_after_read", {31'd0, dio_oe}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] data, input logic flip);
        push_ev(EV_CMD, 32'd3);
        for (int i = 0; i < 32; i++) push_ev(EV_WBIT, {31'd0, data[i]});
        if (flip) push_ev(EV_PERR, 32'd0);
        send_cmd(4'h3, 1'b0);
        bit_(1'b1);
        for (int i = 0; i < 32; i++) bit_(data[i]);
        bit_((^data) ^ flip);
        repeat (3) bit_(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drst_n = 1'b0;
        dio_i  = 1'b1;
        mdrop  = 4'h5;
        repeat (2) @(posedge dck);
        #1;
        check("reset_connected", {31'd0, cif.connected}, 32'd0);
        check("reset_cmd", {28'd0, cif.cmd}, 32'd0);
        check("reset_cmd_vld", {31'd0, cif.cmd_vld}, 32'd0);
        check("reset_dio_oe", {31'd0, dio_oe}, 32'd0);
        check("reset_strobes", {28'd0, cif.serial_wdata_vld, cif.serial_rdata_rdy,
                                cif.serial_parity_err, dio_o}, 32'd0);
        drst_n = 1'b1;
        repeat (3) bit_(1'b1);

        // wrong multidrop address
        connect_seq(4'h3);
        check("connect_wrong_addr", {31'd0, cif.connected}, 32'd0);
        repeat (4) bit_(1'b1);
        check("still_unconnected", {31'd0, cif.connected}, 32'd0);

        // matching address
        mdrop = 4'h3;
        connect_seq(4'h3);
        check("connect_good_addr", {31'd0, cif.connected}, 32'd1);
        repeat (3) bit_(1'b1);

        do_read();
        do_write(32'hC0FFEE15, 1'b0);
        do_write(32'h12345678, 1'b1);

        // command parity error, then a good command
        push_ev(EV_PERR, 32'd0);
        send_cmd(4'h1, 1'b0);
        repeat (4) bit_(1'b1);
        check("perr_keeps_connected", {31'd0, cif.connected}, 32'd1);
        do_read();

        // disconnect command
        push_ev(EV_CMD, 32'd0);
        send_cmd(4'h0, 1'b0);
        bit_(1'b1);
        check("disconnect", {31'd0, cif.connected}, 32'd0);
        repeat (3) bit_(1'b1);
        connect_seq(4'h3);
        check("reconnect", {31'd0, cif.connected}, 32'd1);
        repeat (2) bit_(1'b1);

        // reset in the middle of a read
        push_ev(EV_CMD, 32'd1);
        for (int i = 0; i < 5; i++) push_ev(EV_DIO, {31'd0, IDCODE[i]});
        send_cmd(4'h1, 1'b1);
        repeat (7) bit_(1'b1);
        check("dio_oe_mid_read", {31'd0, dio_oe}, 32'd1);
        #1 drst_n = 1'b0;
        #1;
        check("dio_oe_async_reset", {31'd0, dio_oe}, 32'd0);
        @(posedge dck);
        #1 drst_n = 1'b1;
        check("connected_after_reset", {31'd0, cif.connected}, 32'd0);
        repeat (5) bit_(1'b1);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
